fx_requant_pipe: RTL
====================

Name: fx_requant_pipe

Overview:
- Pipelined signed fixed-point re-quantizer: converts a wide accumulator-format sample to a narrower fixed-point format.
- Applies configurable rounding (LSB side), then saturation or wrap (MSB side), and reports overflow.
- Sits directly upstream of the format-match/delay stage and feeds it a registered, already-narrowed sample.
- Unlike the purely combinational match stage, it carries valid/ready flow control and overflow statistics.

Parameters:
- IN_W, 18, input word width (signed two's complement).
- IN_FRAC, 6, input fractional bits.
- OUT_W, 14, output word width (signed two's complement).
- OUT_FRAC, 2, output fractional bits; constraint IN_FRAC >= OUT_FRAC and (OUT_W-OUT_FRAC) <= (IN_W-IN_FRAC).
- ROUND_MODE, 1, rounding mode: 0 = truncate (floor), 1 = round-half-up, 2 = convergent (round-half-even).
- SAT_EN, 1, overflow handling: 1 = saturate, 0 = wrap (keep low OUT_W bits).
- CNT_W, 16, overflow counter width.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- i_valid  input  1  input sample valid.
- i_ready  output  1  block accepts input this cycle.
- i_data  input  IN_W  input sample.
- o_valid  output  1  output sample valid.
- o_ready  input  1  downstream accepts output.
- o_data  output  OUT_W  re-quantized sample.
- o_ovf  output  1  overflow flag for the current o_data.
- clr_ovf  input  1  clear ovf_sticky and ovf_cnt.
- ovf_sticky  output  1  set on any transferred overflowed sample.
- ovf_cnt  output  CNT_W  count of transferred overflowed samples; saturates at all-ones.

Behaviour:
- Reset (rst_n=0 at a clk edge): both stage valids=0, o_valid=0, o_data=0, o_ovf=0, ovf_sticky=0, ovf_cnt=0. i_ready=1 after reset. Reset mid-stream discards all in-flight samples.
- Pipeline: 2 register stages with a global advance enable en = !o_valid || o_ready. i_ready = en (combinational). Input transfer when i_valid && i_ready. Output transfer when o_valid && o_ready.
- Latency 2 cycles from input transfer to o_valid with no backpressure. Throughput 1 sample/cycle.
- Bubbles propagate as valid=0. When en=0, all stage registers and outputs hold their values.
- Stage 1 (rounding): SHIFT = IN_FRAC-OUT_FRAC. Intermediate width is IN_W-SHIFT+1 (one guard bit for the rounding carry). If SHIFT=0, pass through sign-extended.
  - Mode 0: arithmetic shift right by SHIFT.
  - Mode 1: add 2^(SHIFT-1), then arithmetic shift right.
  - Mode 2: as mode 1, except on an exact tie (discarded bits = 1 followed by zeros) the result is the even neighbour.
- Stage 2 (overflow): range is [-2^(OUT_W-1), 2^(OUT_W-1)-1].
  - Out of range with SAT_EN=1: clamp to the nearest limit and set ovf=1.
  - Out of range with SAT_EN=0: keep the low OUT_W bits and set ovf=1.
  - In range: ovf=0.
  - o_ovf is registered alongside o_data.
- Statistics: update only on an output transfer with o_ovf=1. ovf_sticky<=1; ovf_cnt increments, holding at 2^CNT_W-1.
- clr_ovf=1 clears both. If clr_ovf coincides with a counted transfer: ovf_cnt=1, ovf_sticky=1 (the new event survives the clear).
- Stats are not affected by stalls: a held output is counted once, on its transfer.

Test Plan:
- Defaults, ROUND_MODE=1, o_ready=1: i_data 24, 40, -24, 31 on consecutive cycles -> o_data 2, 3, -1, 2 at cycles +2..+5; o_ovf=0; i_ready constantly 1.
- ROUND_MODE=2, same stimulus -> 2, 2, -2, 2. ROUND_MODE=0 -> 1, 2, -2, 1.
- Saturation, SAT_EN=1: i_data 131064 -> o_data 8191, o_ovf=1, ovf_cnt=1, ovf_sticky=1. i_data -131072 -> o_data -8192, o_ovf=0. SAT_EN=0 with 131064 -> o_data -8192, o_ovf=1.
- Backpressure: stream 10 samples with o_ready=0 for 3 cycles mid-stream.
  - i_ready=0 whenever o_valid=1 and o_ready=0.
  - o_data and o_ovf stable while stalled.
  - All 10 outputs delivered in order, none duplicated or lost.
- Counter edge: CNT_W=2, 5 overflowing transfers -> ovf_cnt 1, 2, 3, 3, 3. Assert clr_ovf on the 5th transfer cycle -> ovf_cnt=1, ovf_sticky=1. A lone clr_ovf with no overflowing transfer -> 0, 0.
- Reset mid-stream: rst_n=0 for 1 cycle with both stages valid -> o_valid=0 and o_data=0 next cycle, stats cleared, no stale sample emitted afterwards; the first new input appears 2 cycles after its transfer.

Source files
------------

// File: rtl/fx_requant_pipe.sv
// Two-stage signed fixed-point re-quantizer: LSB rounding, then MSB saturation/wrap,
// with valid/ready flow control and overflow statistics on the output side.
module fx_requant_pipe #(
    parameter int IN_W       = 18,
    parameter int IN_FRAC    = 6,
    parameter int OUT_W      = 14,
    parameter int OUT_FRAC   = 2,
    parameter int ROUND_MODE = 1,
    parameter int SAT_EN     = 1,
    parameter int CNT_W      = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_valid,
    output logic                    i_ready,
    input  logic signed [IN_W-1:0]  i_data,
    output logic                    o_valid,
    input  logic                    o_ready,
    output logic signed [OUT_W-1:0] o_data,
    output logic                    o_ovf,
    input  logic                    clr_ovf,
    output logic                    ovf_sticky,
    output logic [CNT_W-1:0]        ovf_cnt
);

    localparam int SHIFT   = IN_FRAC - OUT_FRAC;
    // One guard bit above the shifted word absorbs the rounding carry.
    localparam int MID_W   = IN_W - SHIFT + 1;
    localparam int HALF_SH = (SHIFT > 0) ? SHIFT - 1 : 0;

    localparam logic signed [IN_W:0] HALF =
        (SHIFT > 0) ? ((IN_W+1)'(1) << HALF_SH) : '0;
    localparam logic signed [IN_W:0] MASK =
        ((IN_W+1)'(1) << SHIFT) - (IN_W+1)'(1);

    localparam logic signed [OUT_W-1:0] OMAX = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic signed [OUT_W-1:0] OMIN = {1'b1, {(OUT_W-1){1'b0}}};
    localparam logic signed [MID_W-1:0] MAX_M = {{(MID_W-OUT_W){1'b0}}, OMAX};
    localparam logic signed [MID_W-1:0] MIN_M = {{(MID_W-OUT_W){1'b1}}, OMIN};

    // Drop SHIFT fractional bits with the selected rounding rule.
    function automatic logic signed [MID_W-1:0] round_fn(input logic signed [IN_W-1:0] x);
        logic signed [IN_W:0] ext;
        logic signed [IN_W:0] sum;
        logic signed [IN_W:0] shr;
        logic                 tie;
        ext = {x[IN_W-1], x};
        tie = (SHIFT > 0) && ((ext & MASK) == HALF);
        if (ROUND_MODE == 0) begin
            sum = ext;
        end else begin
            sum = ext + HALF;
        end
        shr = sum >>> SHIFT;
        // An exact tie rounded up lands on k+1; clearing the LSB picks the even neighbour.
        if (ROUND_MODE == 2 && tie) begin
            shr[0] = 1'b0;
        end
        return shr[MID_W-1:0];
    endfunction

    // Narrow to OUT_W bits; returns {ovf, data}.
    function automatic logic [OUT_W:0] sat_fn(input logic signed [MID_W-1:0] r);
        logic ovf;
        ovf = (r > MAX_M) || (r < MIN_M);
        if (!ovf) begin
            return {1'b0, r[OUT_W-1:0]};
        end
        if (SAT_EN == 0) begin
            return {1'b1, r[OUT_W-1:0]};
        end
        return {1'b1, r[MID_W-1] ? OMIN : OMAX};
    endfunction

    logic                    en;
    logic                    vld_p1;
    logic signed [MID_W-1:0] rnd_p1;
    logic                    vld_p2;
    logic signed [OUT_W-1:0] data_p2;
    logic                    ovf_p2;
    logic                    xfer_ovf;

    // Whole pipe advances together whenever the output register is free or draining.
    assign en       = !vld_p2 || o_ready;
    assign i_ready  = en;
    assign o_valid  = vld_p2;
    assign o_data   = data_p2;
    assign o_ovf    = ovf_p2;
    assign xfer_ovf = vld_p2 && o_ready && ovf_p2;

    // Stage 1: rounding
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_p1 <= 1'b0;
        end else if (en) begin
            vld_p1 <= i_valid;
            if (i_valid) begin
                rnd_p1 <= round_fn(i_data);
            end
        end
    end

    // Stage 2: saturation / wrap, registered output with its overflow flag
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_p2  <= 1'b0;
            data_p2 <= '0;
            ovf_p2  <= 1'b0;
        end else if (en) begin
            vld_p2 <= vld_p1;
            if (vld_p1) begin
                {ovf_p2, data_p2} <= sat_fn(rnd_p1);
            end
        end
    end

    // Overflow statistics: counted once per transferred overflowed sample; a
    // coincident clear keeps the new event.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ovf_sticky <= 1'b0;
            ovf_cnt    <= '0;
        end else if (clr_ovf) begin
            ovf_sticky <= xfer_ovf;
            ovf_cnt    <= {{(CNT_W-1){1'b0}}, xfer_ovf};
        end else if (xfer_ovf) begin
            ovf_sticky <= 1'b1;
            if (ovf_cnt != {CNT_W{1'b1}}) begin
                ovf_cnt <= ovf_cnt + CNT_W'(1);
            end
        end
    end

endmodule
